// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative shift-add multiply and restoring divide/remainder unit with valid/ready handshakes
module execute_muldiv #(
  parameter int XLEN = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
  localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;
  stateT state, next;
  logic [CNT_W-1:0] cnt;
  logic [2:0] opR;
  logic wordR, negQ, negR;
  logic [XLEN-1:0] acc, mc, q;
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
    return w ? sx(v[31:0]) : v;
  endfunction
  logic [2:0] opIn;
  logic wordIn, sgn, aNeg, bNeg, isDivIn, bz, ovf, special, accept;
  logic [XLEN-1:0] aExt, bExt, aMag, bMag, minNeg, specRaw;
  assign opIn = op > REMU ? MUL : op;
  assign wordIn = word && (XLEN == 64);
  assign sgn = opIn == DIV || opIn == REM;
  assign aExt = wordIn ? (sgn ? sx(a[31:0]) : XLEN'(a[31:0])) : a;
  assign bExt = wordIn ? (sgn ? sx(b[31:0]) : XLEN'(b[31:0])) : b;
  assign aNeg = sgn && aExt[XLEN-1];
  assign bNeg = sgn && bExt[XLEN-1];
  assign aMag = aNeg ? -aExt : aExt;
  assign bMag = bNeg ? -bExt : bExt;
  assign minNeg = wordIn ? sx(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign isDivIn = opIn != MUL;
  assign bz = bExt == '0;
  assign ovf = sgn && aExt == minNeg && bExt == '1;
  assign special = isDivIn && (bz || ovf);
  assign specRaw = (opIn == DIV || opIn == DIVU) ? (bz ? '1 : aExt) : (bz ? aExt : '0);
  assign accept = in_valid && in_ready && !flush;
  logic isMul, ge;
  logic [XLEN:0] shl, diff;
  logic [XLEN-1:0] accN, qN, mcN, raw;
  assign isMul = opR == MUL;
  assign shl = {acc, q[XLEN-1]};
  assign diff = shl - {1'b0, mc};
  assign ge = !diff[XLEN];
  assign accN = isMul ? (q[0] ? acc + mc : acc) : (ge ? diff[XLEN-1:0] : shl[XLEN-1:0]);
  assign qN = isMul ? q >> 1 : {q[XLEN-2:0], ge};
  assign mcN = isMul ? mc << 1 : mc;
  assign raw = isMul ? accN : (opR == DIV || opR == DIVU) ? (negQ ? -qN : qN) : (negR ? -accN : accN);
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // next state: flush wins over accept and completion
  always_comb begin
    next = flush ? IDLE :
           state == IDLE ? (in_valid ? (special ? DONE : RUN) : IDLE) :
           state == RUN  ? (cnt == '0 ? DONE : RUN) :
           (out_ready ? IDLE : DONE);
  end
  // operand capture at accept, one iteration per RUN cycle, result on the last one
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      opR <= MUL;
      wordR <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      acc <= '0;
      mc <= '0;
      q <= '0;
      result <= '0;
    end else if (accept) begin
      cnt <= wordIn ? CNT_W'(31) : CNT_W'(XLEN-1);
      opR <= opIn;
      wordR <= wordIn;
      negQ <= aNeg ^ bNeg;
      negR <= aNeg;
      acc <= '0;
      mc <= isDivIn ? bMag : aExt;
      q <= isDivIn ? (wordIn ? aMag << 32 : aMag) : bExt;
      if (special) result <= fin(specRaw, wordIn);
    end else if (state == RUN && !flush) begin
      cnt <= cnt - 1'b1;
      acc <= accN;
      q <= qN;
      mc <= mcN;
      if (cnt == '0) result <= fin(raw, wordR);
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: directed vectors for the multi-cycle mul/div unit
module tb_execute_muldiv;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0, word = 0;
  logic [2:0] op = 0;
  logic [63:0] a = 0, b = 0, result;
  logic in_ready, out_valid, busy;
  int checks = 0, errors = 0, cyc;
  logic seen;
  execute_muldiv dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic waitDone();
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic runOp(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int lat, input string tag);
    @(negedge clk);
    op = o; word = w; a = x; b = y; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op = 3'($urandom_range(0, 7)); word = 1'($urandom_range(0, 1));
    check({tag, " busy"}, in_ready, 0);
    waitDone();
    if (lat > 0) check({tag, " lat"}, cyc, lat);
    check({tag, " res"}, result, exp);
    @(posedge clk); #1;
    check({tag, " rdy"}, in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst result", result, 0);
    @(negedge clk) reset = 0;
    runOp(0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul");
    runOp(1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div");
    runOp(3, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem");
    runOp(2, 0, 64'd100, 64'd7, 64'd14, 65, "divu");
    runOp(4, 0, 64'd100, 64'd7, 64'd2, 65, "remu");
    runOp(2, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu0");
    runOp(4, 0, 64'd5, 64'd0, 64'd5, 1, "remu0");
    runOp(3, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, "rem0");
    runOp(1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "divovf");
    runOp(3, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "removf");
    runOp(1, 1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, "divwovf");
    runOp(1, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw");
    runOp(0, 1, 64'h10000, 64'h10000, 64'd0, 33, "mulw");
    runOp(2, 1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw");
    runOp(5, 0, 64'd6, 64'd7, 64'd42, 65, "rsvd");
    @(negedge clk);
    op = 2; word = 0; a = 100; b = 7; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    waitDone();
    check("bp lat", cyc, 65);
    in_valid = 1; op = 0; a = 1; b = 1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp valid", out_valid, 1);
      check("bp result", result, 64'd14);
      check("bp in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 0;
    @(posedge clk); #1;
    check("bp drain valid", out_valid, 0);
    check("bp drain rdy", in_ready, 1);
    @(negedge clk);
    op = 1; word = 0; a = 64'hFFFF_FFFF_FFFF_FF9C; b = 3; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (19) @(posedge clk);
    @(negedge clk) flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush busy", busy, 0);
    check("flush valid", out_valid, 0);
    @(negedge clk);
    flush = 1; in_valid = 1; op = 0; a = 2; b = 2;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    check("flush beats accept", busy, 0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("flush no valid", seen, 0);
    runOp(1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd3, 64'hFFFF_FFFF_FFFF_FFDF, 65, "div after flush");
    @(negedge clk);
    op = 2; word = 0; a = 5; b = 0; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    check("done flush pre", out_valid, 1);
    @(negedge clk);
    flush = 1; out_ready = 1;
    @(posedge clk); #1;
    flush = 0;
    check("done flush valid", out_valid, 0);
    check("done flush rdy", in_ready, 1);
    @(negedge clk);
    op = 0; word = 0; a = 3; b = 5; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #3 reset = 1;
    #1;
    check("arst busy", busy, 0);
    check("arst valid", out_valid, 0);
    check("arst rdy", in_ready, 1);
    check("arst result", result, 0);
    #3 reset = 0;
    runOp(0, 0, 64'd3, 64'd5, 64'd15, 65, "mul after reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
